dram_arbiter: RTL and testbench

- Shares the single-port 64K x 8 image data memory between two requesters: port 0 (processor load/store unit) and port 1 (image I/O loader/unloader).
- Accepts one access per cycle under round-robin priority, with optional locked bursts for streaming pixel transfers.
- Drives the memory's registered command inputs and routes read data back to the requester that issued the read.

---
 rtl/dram_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_dram_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port registered image memory, with locked bursts.
// Optional per-port grant and conflict counters are built when ARB_STATS_EN is defined.
module dram_arbiter #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 8,
   parameter int BURST_MAX = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic              lock0,
   input  logic              lock1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [1:0]        dbg_state
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]       stat_gnt0,
   output logic [31:0]       stat_gnt1,
   output logic [31:0]       stat_conflict
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam logic [7:0] BMAX = 8'(BURST_MAX);

   state_t              state_q, state_d;
   logic                prio_q, prio_d;
   logic [7:0]          burst_cnt_q, burst_cnt_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_din_q, mem_din_d;
   logic                mem_write_q, mem_write_d;
   logic                mem_read_q, mem_read_d;
   logic                tag_v1_q, tag_v1_d;
   logic                tag_p1_q, tag_p1_d;
   logic                tag_v2_q, tag_v2_d;
   logic                tag_p2_q, tag_p2_d;
   logic                rvalid0_q, rvalid0_d;
   logic                rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic                acc;
   logic                winner;
   logic                w_we;
   logic                w_lock;
   logic [ADDR_W-1:0]   w_addr;
   logic [DATA_W-1:0]   w_din;
   logic [7:0]          cnt_inc;

`ifdef ARB_STATS_EN
   logic [31:0]         stat_gnt0_q, stat_gnt0_d;
   logic [31:0]         stat_gnt1_q, stat_gnt1_d;
   logic [31:0]         stat_conflict_q, stat_conflict_d;
   logic                refused;
`endif

   // Grant is combinational so a transfer completes at the same edge it is requested.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (req0 && req1) begin
                  gnt0 = ~prio_q;
                  gnt1 = prio_q;
               end else begin
                  gnt0 = req0;
                  gnt1 = req1;
               end
            end
            OWN0:    gnt0 = req0;
            OWN1:    gnt1 = req1;
            default: ;
         endcase
      end
   end

   always_comb begin
      acc     = gnt0 | gnt1;
      winner  = gnt1;
      w_we    = winner ? we1    : we0;
      w_lock  = winner ? lock1  : lock0;
      w_addr  = winner ? addr1  : addr0;
      w_din   = winner ? wdata1 : wdata0;
      cnt_inc = (state_q == IDLE) ? 8'd1 : burst_cnt_q + 8'd1;
   end

   // Ownership and priority; a burst is released early when the owner drops lock
   // or is forcibly released once it has completed BURST_MAX transfers.
   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      burst_cnt_d = burst_cnt_q;
      if (acc) begin
         if (w_lock && (cnt_inc != BMAX)) begin
            state_d     = winner ? OWN1 : OWN0;
            burst_cnt_d = cnt_inc;
         end else begin
            state_d     = IDLE;
            prio_d      = ~winner;
            burst_cnt_d = 8'd0;
         end
      end else if ((state_q == OWN0 && !req0 && !lock0) ||
                   (state_q == OWN1 && !req1 && !lock1)) begin
         state_d     = IDLE;
         burst_cnt_d = 8'd0;
      end
   end

   always_comb begin
      mem_addr_d  = acc ? w_addr : mem_addr_q;
      mem_din_d   = acc ? w_din  : mem_din_q;
      mem_write_d = acc &  w_we;
      mem_read_d  = acc & ~w_we;
   end

   // Read tag follows the command through the memory's two registered stages.
   always_comb begin
      tag_v1_d  = acc & ~w_we;
      tag_p1_d  = winner;
      tag_v2_d  = tag_v1_q;
      tag_p2_d  = tag_p1_q;
      rvalid0_d = tag_v2_q & ~tag_p2_q;
      rvalid1_d = tag_v2_q &  tag_p2_q;
      rdata_d   = tag_v2_q ? mem_dout : rdata_q;
   end

`ifdef ARB_STATS_EN
   always_comb begin
      refused         = (req0 & ~gnt0) | (req1 & ~gnt1);
      stat_gnt0_d     = stat_gnt0_q;
      stat_gnt1_d     = stat_gnt1_q;
      stat_conflict_d = stat_conflict_q;
      if (gnt0 && (stat_gnt0_q != 32'hFFFF_FFFF))
         stat_gnt0_d = stat_gnt0_q + 32'd1;
      if (gnt1 && (stat_gnt1_q != 32'hFFFF_FFFF))
         stat_gnt1_d = stat_gnt1_q + 32'd1;
      if (refused && (stat_conflict_q != 32'hFFFF_FFFF))
         stat_conflict_d = stat_conflict_q + 32'd1;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         prio_q          <= 1'b0;
         burst_cnt_q     <= 8'd0;
         mem_addr_q      <= '0;
         mem_din_q       <= '0;
         mem_write_q     <= 1'b0;
         mem_read_q      <= 1'b0;
         tag_v1_q        <= 1'b0;
         tag_p1_q        <= 1'b0;
         tag_v2_q        <= 1'b0;
         tag_p2_q        <= 1'b0;
         rvalid0_q       <= 1'b0;
         rvalid1_q       <= 1'b0;
         rdata_q         <= '0;
`ifdef ARB_STATS_EN
         stat_gnt0_q     <= 32'd0;
         stat_gnt1_q     <= 32'd0;
         stat_conflict_q <= 32'd0;
`endif
      end else begin
         state_q         <= state_d;
         prio_q          <= prio_d;
         burst_cnt_q     <= burst_cnt_d;
         mem_addr_q      <= mem_addr_d;
         mem_din_q       <= mem_din_d;
         mem_write_q     <= mem_write_d;
         mem_read_q      <= mem_read_d;
         tag_v1_q        <= tag_v1_d;
         tag_p1_q        <= tag_p1_d;
         tag_v2_q        <= tag_v2_d;
         tag_p2_q        <= tag_p2_d;
         rvalid0_q       <= rvalid0_d;
         rvalid1_q       <= rvalid1_d;
         rdata_q         <= rdata_d;
`ifdef ARB_STATS_EN
         stat_gnt0_q     <= stat_gnt0_d;
         stat_gnt1_q     <= stat_gnt1_d;
         stat_conflict_q <= stat_conflict_d;
`endif
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_din   = mem_din_q;
   assign mem_write = mem_write_q;
   assign mem_read  = mem_read_q;
   assign rvalid0   = rvalid0_q;
   assign rvalid1   = rvalid1_q;
   assign rdata     = rdata_q;
   assign dbg_state = state_q;

`ifdef ARB_STATS_EN
   assign stat_gnt0     = stat_gnt0_q;
   assign stat_gnt1     = stat_gnt1_q;
   assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: transaction-level reference model checked every cycle plus directed scenarios.
module tb_dram_arbiter;

   localparam int BURST_MAX = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, we0, we1, lock0, lock1;
   logic [15:0] addr0, addr1;
   logic [7:0]  wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [7:0]  rdata;
   logic [15:0] mem_addr;
   logic [7:0]  mem_din;
   logic        mem_write, mem_read;
   logic [7:0]  mem_dout;
   logic [1:0]  dbg_state;
`ifdef ARB_STATS_EN
   logic [31:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

   int total = 0;
   int bad   = 0;

   dram_arbiter #(.ADDR_W(16), .DATA_W(8), .BURST_MAX(BURST_MAX)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .lock0(lock0), .lock1(lock1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_write(mem_write), .mem_read(mem_read), .mem_dout(mem_dout),
      .dbg_state(dbg_state)
`ifdef ARB_STATS_EN
      , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   // memory device attached to the DUT
   logic [7:0] mem [0:65535];
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= mem_din;
      if (mem_read)  mem_dout <= mem[mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference model: transaction order against a shadow memory
   typedef struct {
      int        due;
      logic      port;
      logic [7:0] data;
   } rd_t;

   logic [7:0] shadow [0:65535];
   rd_t        rd_q[$];
   bit         model_on = 0;
   int         cyc = 0;
   int         m_own;
   logic       m_prio;
   int         m_cnt;
   logic [15:0] e_addr;
   logic [7:0]  e_din, e_rdata;
   logic        e_wr, e_rd, e_rv0, e_rv1;

   function automatic logic [1:0] exp_gnt(logic r0, logic r1, logic rs, int own, logic pr);
      if (rs) return 2'b00;
      if (own == 0) return {1'b0, r0};
      if (own == 1) return {r1, 1'b0};
      if (r0 && r1) return pr ? 2'b10 : 2'b01;
      return {r1, r0};
   endfunction

   always @(posedge clk) begin
      logic [1:0] g;
      logic w, wwe, wlk;
      logic [15:0] wa;
      logic [7:0] wd;
      int nxt;
      if (rst) begin
         model_on = 1;
         m_own = 2; m_prio = 0; m_cnt = 0;
         e_addr = 0; e_din = 0; e_wr = 0; e_rd = 0;
         e_rv0 = 0; e_rv1 = 0; e_rdata = 0;
         rd_q.delete();
      end else if (model_on) begin
         cyc++;
         g = exp_gnt(req0, req1, 1'b0, m_own, m_prio);
         e_rv0 = 0; e_rv1 = 0; e_wr = 0; e_rd = 0;
         if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            e_rdata = rd_q[0].data;
            if (rd_q[0].port) e_rv1 = 1; else e_rv0 = 1;
            void'(rd_q.pop_front());
         end
         if (g != 2'b00) begin
            w   = g[1];
            wwe = w ? we1 : we0;
            wlk = w ? lock1 : lock0;
            wa  = w ? addr1 : addr0;
            wd  = w ? wdata1 : wdata0;
            e_addr = wa; e_din = wd; e_wr = wwe; e_rd = !wwe;
            if (wwe) shadow[wa] = wd;
            else rd_q.push_back('{due: cyc + 2, port: w, data: shadow[wa]});
            nxt = (m_own == 2) ? 1 : m_cnt + 1;
            if (wlk && nxt < BURST_MAX) begin
               m_own = w ? 1 : 0; m_cnt = nxt;
            end else begin
               m_own = 2; m_prio = !w; m_cnt = 0;
            end
         end else if ((m_own == 0 && !req0 && !lock0) || (m_own == 1 && !req1 && !lock1)) begin
            m_own = 2; m_cnt = 0;
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      logic [1:0] eg;
      if (model_on) begin
         eg = exp_gnt(req0, req1, rst, m_own, m_prio);
         check("gnt0", gnt0, eg[0]);
         check("gnt1", gnt1, eg[1]);
         check("mem_addr", mem_addr, e_addr);
         check("mem_din", mem_din, e_din);
         check("mem_write", mem_write, e_wr);
         check("mem_read", mem_read, e_rd);
         check("rvalid0", rvalid0, e_rv0);
         check("rvalid1", rvalid1, e_rv1);
         check("rdata", rdata, e_rdata);
      end
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: simulation did not complete");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   task automatic do_reset();
      rst = 1; req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
      tick(); tick();
      rst = 0;
   endtask

   initial begin
      int sent, n1_before;
      bit got0;
      for (int i = 0; i < 65536; i++) begin
         mem[i] = 8'h00;
         shadow[i] = 8'h00;
      end
      mem[16'h0010] = 8'hA5;
      shadow[16'h0010] = 8'hA5;
      rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      tick(); tick(); tick();
      check("reset_mem_read", mem_read, 0);
      check("reset_rvalid0", rvalid0, 0);
      check("reset_mem_addr", mem_addr, 0);
      rst = 0;

      // single read on port 0
      req0 = 1; we0 = 0; addr0 = 16'h0010;
      #1 check("t1_gnt0", gnt0, 1);
      tick();
      req0 = 0;
      check("t1_mem_read", mem_read, 1);
      check("t1_mem_addr", mem_addr, 16'h0010);
      tick(); tick();
      check("t1_rvalid0", rvalid0, 1);
      check("t1_rdata", rdata, 8'hA5);
      check("t1_rvalid1", rvalid1, 0);

      // contended reads alternate starting with port 0
      do_reset();
      req0 = 1; req1 = 1; we0 = 0; we1 = 0;
      for (int i = 0; i < 8; i++) begin
         addr0 = 16'h0100 + 16'(i); addr1 = 16'h0200 + 16'(i);
         #1;
         check("t2_gnt0", gnt0, (i % 2) == 0);
         check("t2_gnt1", gnt1, (i % 2) == 1);
         tick();
      end
      req0 = 0; req1 = 0;
      tick(); tick(); tick();

      // locked write on port 1 holds port 0 off, then port 0 reads it back
      req1 = 1; we1 = 1; lock1 = 1; addr1 = 16'h1234; wdata1 = 8'h3C;
      #1 check("t3_gnt1", gnt1, 1);
      tick();
      req0 = 1; we0 = 0; addr0 = 16'h1234; addr1 = 16'h1235; wdata1 = 8'h11;
      #1 check("t3_gnt0_locked_a", gnt0, 0);
      tick();
      req1 = 0;
      #1 check("t3_gnt0_held_idle", gnt0, 0);
      tick();
      req1 = 1; lock1 = 0; addr1 = 16'h1236; wdata1 = 8'h22;
      #1 check("t3_gnt0_locked_b", gnt0, 0);
      tick();
      req1 = 0;
      #1 check("t3_gnt0_after", gnt0, 1);
      tick();
      req0 = 0;
      tick(); tick();
      check("t3_rvalid0", rvalid0, 1);
      check("t3_rdata", rdata, 8'h3C);

      // 20 locked writes on port 1: forced release after 16
      sent = 0; n1_before = -1; got0 = 0;
      req0 = 1; we0 = 0; addr0 = 16'h2000;
      req1 = 1; we1 = 1; lock1 = 1;
      for (int c = 0; c < 60 && (sent < 20 || !got0); c++) begin
         addr1 = 16'h2000 + 16'(sent); wdata1 = 8'(sent);
         #1;
         if (gnt0 && !got0) begin
            n1_before = sent;
            got0 = 1;
         end
         if (gnt1) sent++;
         tick();
         if (got0) req0 = 0;
         if (sent >= 20) begin req1 = 0; lock1 = 0; end
      end
      req0 = 0; req1 = 0; lock1 = 0;
      check("t4_p1_before_p0", n1_before, 16);
      check("t4_p0_granted", got0, 1);
      check("t4_p1_total", sent, 20);
      tick(); tick(); tick();

      // read-after-write on consecutive edges
      req0 = 1; we0 = 1; addr0 = 16'h0300; wdata0 = 8'h5A;
      #1 check("t6_gnt0_w", gnt0, 1);
      tick();
      we0 = 0;
      #1 check("t6_gnt0_r", gnt0, 1);
      tick();
      req0 = 0;
      tick(); tick();
      check("t6_rvalid0", rvalid0, 1);
      check("t6_rdata", rdata, 8'h5A);

      // reset while two reads are in flight
      req0 = 1; we0 = 0; addr0 = 16'h0010;
      tick();
      addr0 = 16'h0011;
      tick();
      rst = 1; req0 = 0;
      tick();
      check("t5_mem_read", mem_read, 0);
      check("t5_mem_addr", mem_addr, 0);
      check("t5_rvalid0", rvalid0, 0);
      check("t5_rdata", rdata, 0);
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t5_no_rvalid0", rvalid0, 0);
      end

`ifdef ARB_STATS_EN
      do_reset();
      req0 = 1; req1 = 1; we0 = 0; we1 = 0;
      for (int i = 0; i < 10; i++) tick();
      req0 = 0; req1 = 0;
      check("st_gnt0", stat_gnt0, 5);
      check("st_gnt1", stat_gnt1, 5);
      check("st_conflict", stat_conflict, 10);
      tick(); tick(); tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
